// File: rtl/ulpi_reg_read.sv
// ulpi_reg_read: link-side ULPI register-read engine (RegRead TX CMD, turnaround, byte capture).
// Optional TXCMD wait timeout is built in when ULPI_REG_READ_TIMEOUT_EN is defined.
module ulpi_reg_read #(
  parameter int MAX_RETRIES = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RD,
  input  logic [5:0] ADDR,
  output logic [7:0] DATA,
  output logic       valid,
  output logic       err,
  output logic       busy,
  input  logic       DIR,
  input  logic       NXT,
  input  logic [7:0] ULPI_DATA_IN,
  output logic [7:0] ULPI_DATA,
  output logic       ULPI_OE
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_TURN0, S_TXCMD, S_TA1, S_RDDAT, S_DONE
  } state_t;

  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRIES);

  state_t        state, state_nxt;
  logic [5:0]    addr_q;
  logic [RW-1:0] retry_q;
  logic          valid_nxt, err_nxt, retry_inc, timeout;

`ifdef ULPI_REG_READ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;

  // Counts consecutive TXCMD cycles; any other state restarts it from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 to_cnt <= '0;
    else if (state != S_TXCMD) to_cnt <= '0;
    else                      to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = (state == S_TXCMD) && !DIR && !NXT && (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      retry_q <= '0;
      DATA    <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      state <= state_nxt;
      valid <= valid_nxt;
      err   <= err_nxt;
      if (state == S_IDLE) begin
        retry_q <= '0;
        if (RD) addr_q <= ADDR;
      end else if (retry_inc) begin
        retry_q <= retry_q + 1'b1;
      end
      if (valid_nxt) DATA <= ULPI_DATA_IN;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_nxt = state;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    retry_inc = 1'b0;
    unique case (state)
      S_IDLE:  if (RD) state_nxt = DIR ? S_WAIT : S_TXCMD;
      S_WAIT:  if (!DIR) state_nxt = S_TURN0;
      S_TURN0: state_nxt = DIR ? S_WAIT : S_TXCMD;
      S_TXCMD: begin
        // PHY grabbing the bus wins over NXT: the TX CMD was preempted by an RX CMD.
        if (DIR) begin
          if (retry_q < MAX_R) begin
            retry_inc = 1'b1;
            state_nxt = S_WAIT;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = S_IDLE;
          end
        end else if (NXT) begin
          state_nxt = S_TA1;
        end else if (timeout) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_TA1: begin
        state_nxt = DIR ? S_RDDAT : S_IDLE;
        err_nxt   = !DIR;
      end
      S_RDDAT: begin
        if (DIR) begin
          valid_nxt = 1'b1;
          state_nxt = S_DONE;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DONE:  if (!DIR) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // OE follows DIR combinationally so the link lets go in the same cycle the PHY grabs the bus.
  always_comb begin
    busy      = (state != S_IDLE);
    ULPI_OE   = (state == S_TXCMD) && !DIR;
    ULPI_DATA = (state == S_TXCMD) ? {2'b11, addr_q} : 8'h00;
  end

endmodule

// File: tb/tb_ulpi_reg_read.sv
// tb_ulpi_reg_read: directed table, hand sequences and randomized transactions for ulpi_reg_read.
// Timeout section depends on ULPI_REG_READ_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_ulpi_reg_read;
  localparam int MAX_RETRIES = 1;
  localparam int TIMEOUT_CYC = 8;

  logic       clk = 1'b0, rst = 1'b0, RD = 1'b0, DIR = 1'b0, NXT = 1'b0;
  logic [5:0] ADDR = '0;
  logic [7:0] ULPI_DATA_IN = '0;
  logic [7:0] DATA, ULPI_DATA;
  logic       valid, err, busy, ULPI_OE;

  int   vectors = 0, miscompares = 0;
  int   n_valid = 0, n_err = 0;
  bit   both_seen = 1'b0;
  logic [7:0] model_data = 8'h00;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
    int         pre_wait;   // cycles PHY holds DIR high when RD arrives
    int         aborts;     // TX CMD attempts preempted by DIR
    int         nxt_delay;  // TXCMD cycles before NXT
    int         bad;        // 1: DIR low in TA1, 2: DIR low in RDDAT
    bit         exp_valid;
    bit         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  ulpi_reg_read #(.MAX_RETRIES(MAX_RETRIES), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst), .RD(RD), .ADDR(ADDR), .DATA(DATA), .valid(valid), .err(err),
    .busy(busy), .DIR(DIR), .NXT(NXT), .ULPI_DATA_IN(ULPI_DATA_IN), .ULPI_DATA(ULPI_DATA),
    .ULPI_OE(ULPI_OE)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (valid) n_valid++;
      if (err) n_err++;
      if (valid && err) both_seen = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outcome from the read rules alone: too many preemptions or a broken turnaround is an error.
  function automatic vec_t predict(input vec_t v, input logic [7:0] cur);
    vec_t r = v;
    if (v.aborts > MAX_RETRIES || v.bad != 0) begin
      r.exp_valid = 1'b0; r.exp_err = 1'b1; r.exp_data = cur;
    end else begin
      r.exp_valid = 1'b1; r.exp_err = 1'b0; r.exp_data = v.data;
    end
    return r;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; RD = 1'b0; DIR = 1'b0; NXT = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_data = 8'h00;
  endtask

  task automatic wait_oe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      #1;
      if (ULPI_OE) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic do_txn(input vec_t v);
    int v0, e0;
    bit ok, done;
    v0 = n_valid; e0 = n_err; both_seen = 1'b0; done = 1'b0; ok = 1'b1;
    ADDR = v.addr; RD = 1'b1; DIR = (v.pre_wait > 0); NXT = 1'b0;
    @(negedge clk);
    RD = 1'b0; ADDR = 6'($urandom);
    if (v.pre_wait > 0) begin
      #1; check("oe_low_while_phy_owns", ULPI_OE, 0);
      repeat (v.pre_wait - 1) @(negedge clk);
      DIR = 1'b0;
      @(negedge clk);
    end
    for (int k = 0; k <= v.aborts && !done && ok; k++) begin
      wait_oe(ok);
      check("txcmd_reached", ok, 1);
      if (ok) begin
        check("txcmd_byte", ULPI_DATA, {2'b11, v.addr});
        if (k < v.aborts) begin
          DIR = 1'b1;
          #1; check("oe_drops_on_abort", ULPI_OE, 0);
          if (k >= MAX_RETRIES) done = 1'b1;
          @(negedge clk); @(negedge clk);
          DIR = 1'b0;
          @(negedge clk);
        end
      end
    end
    if (!ok) begin
      apply_reset();
    end else begin
      if (!done) begin
        repeat (v.nxt_delay) @(negedge clk);
        NXT = 1'b1;
        @(negedge clk);
        NXT = 1'b0; DIR = (v.bad != 1);
        @(negedge clk);
        DIR = (v.bad != 2); ULPI_DATA_IN = v.data;
        @(negedge clk);
        ULPI_DATA_IN = 8'($urandom);
      end
      DIR = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("valid_pulses", n_valid - v0, v.exp_valid);
      check("err_pulses", n_err - e0, v.exp_err);
      check("data_out", DATA, v.exp_data);
      check("busy_idle", busy, 0);
      check("oe_idle", ULPI_OE, 0);
      check("valid_err_exclusive", both_seen, 0);
      model_data = v.exp_data;
    end
  endtask

  vec_t tbl[7];
  vec_t rv;
  int   v0, e0;

  initial begin
    tbl[0] = '{6'h1A, 8'h3A, 0, 0, 0, 0, 1'b1, 1'b0, 8'h3A};
    tbl[1] = '{6'h04, 8'h55, 3, 0, 1, 0, 1'b1, 1'b0, 8'h55};
    tbl[2] = '{6'h2C, 8'hA5, 0, 1, 0, 0, 1'b1, 1'b0, 8'hA5};
    tbl[3] = '{6'h15, 8'h77, 1, 2, 0, 0, 1'b0, 1'b1, 8'hA5};
    tbl[4] = '{6'h3F, 8'h11, 0, 0, 2, 1, 1'b0, 1'b1, 8'hA5};
    tbl[5] = '{6'h00, 8'hFF, 2, 1, 1, 2, 1'b0, 1'b1, 8'hA5};
    tbl[6] = '{6'h21, 8'h6B, 0, 0, 3, 0, 1'b1, 1'b0, 8'h6B};

    // Reset state
    #2;
    check("rst_data", DATA, 0);
    check("rst_valid", valid, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_oe", ULPI_OE, 0);
    check("rst_ulpi_data", ULPI_DATA, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Idle bus, NXT on first TXCMD cycle: exact cycle-by-cycle latency
    ADDR = 6'h1A; RD = 1'b1; DIR = 1'b0;
    @(negedge clk); RD = 1'b0;
    #1; check("lat_oe_txcmd", ULPI_OE, 1);
    check("lat_txcmd_byte", ULPI_DATA, 8'hDA);
    check("lat_busy", busy, 1);
    NXT = 1'b1;
    @(negedge clk); NXT = 1'b0; DIR = 1'b1;
    #1; check("lat_oe_ta1", ULPI_OE, 0);
    check("lat_no_early_valid1", valid, 0);
    @(negedge clk); ULPI_DATA_IN = 8'h3A;
    #1; check("lat_no_early_valid2", valid, 0);
    @(negedge clk);
    #1; check("lat_valid", valid, 1);
    check("lat_data", DATA, 8'h3A);
    DIR = 1'b0;
    @(negedge clk);
    #1; check("lat_valid_one_cycle", valid, 0);
    check("lat_busy_drop", busy, 0);

    // PHY owns bus at RD: TX CMD appears two cycles after DIR falls
    DIR = 1'b1; ADDR = 6'h04; RD = 1'b1;
    @(negedge clk); RD = 1'b0;
    #1; check("wait_oe0", ULPI_OE, 0);
    check("wait_busy", busy, 1);
    @(negedge clk);
    #1; check("wait_oe1", ULPI_OE, 0);
    DIR = 1'b0;
    @(negedge clk);
    #1; check("turn_oe", ULPI_OE, 0);
    @(negedge clk);
    #1; check("turn_txcmd_oe", ULPI_OE, 1);
    check("turn_txcmd_byte", ULPI_DATA, 8'hC4);
    NXT = 1'b1;
    @(negedge clk); NXT = 1'b0; DIR = 1'b1;
    @(negedge clk); ULPI_DATA_IN = 8'h5C;
    @(negedge clk);
    #1; check("turn_data", DATA, 8'h5C);
    DIR = 1'b0;
    @(negedge clk);
    model_data = 8'h5C;

    // Directed table
    for (int i = 0; i < 7; i++) do_txn(tbl[i]);

    // Reset while in RDDAT: everything clears immediately, no pulse
    ADDR = 6'h2A; RD = 1'b1; DIR = 1'b0;
    @(negedge clk); RD = 1'b0; NXT = 1'b1;
    @(negedge clk); NXT = 1'b0; DIR = 1'b1;
    @(negedge clk); ULPI_DATA_IN = 8'h99;
    #1; check("rddat_busy", busy, 1);
    v0 = n_valid; e0 = n_err;
    rst = 1'b0;
    #1;
    check("midrst_data", DATA, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", valid, 0);
    check("midrst_err", err, 0);
    check("midrst_oe", ULPI_OE, 0);
    DIR = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1; check("midrst_no_pulse", (n_valid - v0) + (n_err - e0), 0);
    model_data = 8'h00;

`ifdef ULPI_REG_READ_TIMEOUT_EN
    // NXT never comes: err exactly TIMEOUT_CYC cycles after TXCMD entry
    e0 = n_err;
    ADDR = 6'h33; RD = 1'b1; DIR = 1'b0; NXT = 1'b0;
    @(negedge clk); RD = 1'b0;
    #1; check("to_txcmd", ULPI_OE, 1);
    for (int i = 1; i < TIMEOUT_CYC; i++) begin
      @(negedge clk);
      #1; check("to_no_early_err", err, 0);
    end
    @(negedge clk);
    #1; check("to_err", err, 1);
    check("to_oe", ULPI_OE, 0);
    check("to_busy", busy, 0);
    @(negedge clk);
    #1; check("to_err_count", n_err - e0, 1);
    check("to_data", DATA, model_data);
`else
    // No timeout build: TXCMD waits indefinitely for NXT
    e0 = n_err;
    ADDR = 6'h33; RD = 1'b1; DIR = 1'b0; NXT = 1'b0;
    @(negedge clk); RD = 1'b0;
    repeat (20) @(negedge clk);
    #1; check("nto_oe", ULPI_OE, 1);
    check("nto_busy", busy, 1);
    check("nto_no_err", n_err - e0, 0);
    NXT = 1'b1;
    @(negedge clk); NXT = 1'b0; DIR = 1'b1;
    @(negedge clk); ULPI_DATA_IN = 8'h81;
    @(negedge clk);
    #1; check("nto_valid", valid, 1);
    check("nto_data", DATA, 8'h81);
    DIR = 1'b0;
    @(negedge clk);
    model_data = 8'h81;
`endif

    // Randomized transactions against the outcome model
    for (int i = 0; i < 40; i++) begin
      rv.addr      = 6'($urandom);
      rv.data      = 8'($urandom);
      rv.pre_wait  = int'($urandom_range(0, 3));
      rv.aborts    = int'($urandom_range(0, MAX_RETRIES + 1));
      rv.nxt_delay = int'($urandom_range(0, 3));
      rv.bad       = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      rv = predict(rv, model_data);
      do_txn(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
